// File: rtl/rx_fifo_sched.sv
// Pulls 32-bit words from the 0.9GHz and 2.4GHz RX FIFOs and serializes them MSB-first
// as bytes toward the SMI side. In round-robin mode a channel is drained in bursts.
module rx_fifo_sched #(
    parameter int BURST_LEN = 4
) (
    input  logic        i_sys_clk,
    input  logic        i_reset,
    input  logic [1:0]  i_mode,
    input  logic        i_empty_09,
    input  logic        i_empty_24,
    output logic        o_pull_09,
    output logic        o_pull_24,
    input  logic [31:0] i_data_09,
    input  logic [31:0] i_data_24,
    output logic [7:0]  o_byte,
    output logic        o_byte_valid,
    input  logic        i_byte_ready,
    output logic        o_sof,
    output logic        o_chan,
    output logic        o_busy
);

    localparam logic [3:0] BURST_LIMIT = 4'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, REQ, LATCH, SEND} state_t;

    state_t      state;
    state_t      state_next;
    logic        last_grant;
    logic        last_grant_next;
    logic        chan_next;
    logic        pull_09_next;
    logic        pull_24_next;
    logic [3:0]  burst_cnt;
    logic [3:0]  burst_next;
    logic [1:0]  byte_idx;
    logic [31:0] word_sr;
    logic        elig_09;
    logic        elig_24;
    logic        accept;
    logic        same_elig;
    logic        burst_room;

    assign elig_09    = i_mode[0] & ~i_empty_09;
    assign elig_24    = i_mode[1] & ~i_empty_24;
    assign accept     = (state == SEND) & i_byte_ready;
    assign same_elig  = o_chan ? elig_24 : elig_09;
    // The burst limit only applies in round-robin; single-channel modes stream indefinitely
    assign burst_room = (i_mode != 2'b11) || (burst_cnt < BURST_LIMIT);

    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        chan_next       = o_chan;
        last_grant_next = last_grant;
        burst_next      = burst_cnt;
        pull_09_next    = 1'b0;
        pull_24_next    = 1'b0;
        case (state)
            IDLE: begin
                if (elig_09 || elig_24) begin
                    if (elig_09 && elig_24) begin
                        chan_next = ~last_grant;
                    end else begin
                        chan_next = elig_24;
                    end
                    last_grant_next = chan_next;
                    burst_next      = '0;
                    pull_09_next    = ~chan_next;
                    pull_24_next    = chan_next;
                    state_next      = REQ;
                end
            end
            REQ:   state_next = LATCH;
            LATCH: state_next = SEND;
            SEND: begin
                if (accept && (byte_idx == 2'd3)) begin
                    if (same_elig && burst_room) begin
                        pull_09_next = ~o_chan;
                        pull_24_next = o_chan;
                        if (burst_cnt < BURST_LIMIT) begin
                            burst_next = burst_cnt + 4'd1;
                        end
                        state_next = REQ;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pulls are registered so they appear exactly in the REQ cycle; the word is latched one cycle later
    always_ff @(posedge i_sys_clk or posedge i_reset) begin
        if (i_reset) begin
            o_pull_09  <= 1'b0;
            o_pull_24  <= 1'b0;
            o_chan     <= 1'b0;
            last_grant <= 1'b1;
            burst_cnt  <= '0;
            byte_idx   <= '0;
            word_sr    <= '0;
        end else begin
            o_pull_09  <= pull_09_next;
            o_pull_24  <= pull_24_next;
            o_chan     <= chan_next;
            last_grant <= last_grant_next;
            burst_cnt  <= burst_next;
            if (state == LATCH) begin
                word_sr  <= o_chan ? i_data_24 : i_data_09;
                byte_idx <= '0;
            end else if (accept) begin
                word_sr  <= {word_sr[23:0], 8'h00};
                byte_idx <= byte_idx + 2'd1;
            end
        end
    end

    assign o_byte       = word_sr[31:24];
    assign o_byte_valid = (state == SEND);
    assign o_sof        = (state == SEND) && (byte_idx == 2'd0);
    assign o_busy       = (state != IDLE);

endmodule

// File: tb/tb_rx_fifo_sched.sv
// Randomized and directed bench for rx_fifo_sched: FIFO models on both channels and a
// timeline-based reference that predicts pulls, bytes and flags cycle by cycle.
module tb_rx_fifo_sched;

    localparam int BURST_LEN = 4;

    logic        i_sys_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [1:0]  i_mode = 2'b00;
    logic        i_empty_09 = 1'b1;
    logic        i_empty_24 = 1'b1;
    logic [31:0] i_data_09 = '0;
    logic [31:0] i_data_24 = '0;
    logic        i_byte_ready = 1'b0;
    logic        o_pull_09;
    logic        o_pull_24;
    logic [7:0]  o_byte;
    logic        o_byte_valid;
    logic        o_sof;
    logic        o_chan;
    logic        o_busy;

    rx_fifo_sched #(.BURST_LEN(BURST_LEN)) dut (
        .i_sys_clk    (i_sys_clk),
        .i_reset      (i_reset),
        .i_mode       (i_mode),
        .i_empty_09   (i_empty_09),
        .i_empty_24   (i_empty_24),
        .o_pull_09    (o_pull_09),
        .o_pull_24    (o_pull_24),
        .i_data_09    (i_data_09),
        .i_data_24    (i_data_24),
        .o_byte       (o_byte),
        .o_byte_valid (o_byte_valid),
        .i_byte_ready (i_byte_ready),
        .o_sof        (o_sof),
        .o_chan       (o_chan),
        .o_busy       (o_busy)
    );

    always #5 i_sys_clk = ~i_sys_clk;

    int n_checks = 0;
    int n_fail = 0;

    // FIFO contents and words queued by directed phases
    logic [31:0] q09[$];
    logic [31:0] q24[$];
    logic [31:0] add09[$];
    logic [31:0] add24[$];

    // Stimulus knobs
    logic [1:0] cfg_mode = 2'b00;
    int         cfg_ready = 1;
    bit         cfg_rand_mode = 1'b0;
    int         cfg_push_pct = 0;
    bit         release_req = 1'b0;

    // Reference timeline: a granted word pulls at grant+1 and offers bytes from grant+3
    int         cyc = 0;
    bit         m_engaged;
    bit         m_chan;
    bit         m_last;
    int         m_burst;
    int         m_pull_at;
    int         m_send_from;
    logic [7:0] m_bytes[$];

    logic [7:0] seen_bytes[$];
    int         pull_log[$];
    int         acc_count = 0;

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_engaged   = 1'b0;
        m_chan      = 1'b0;
        m_last      = 1'b1;
        m_burst     = 0;
        m_pull_at   = -1;
        m_send_from = 0;
        m_bytes.delete();
    endtask

    task automatic start_word(input bit ch);
        logic [31:0] w;
        w = ch ? q24[0] : q09[0];
        m_chan      = ch;
        m_last      = ch;
        m_engaged   = 1'b1;
        m_pull_at   = cyc + 1;
        m_send_from = cyc + 3;
        m_bytes.delete();
        m_bytes.push_back(w[31:24]);
        m_bytes.push_back(w[23:16]);
        m_bytes.push_back(w[15:8]);
        m_bytes.push_back(w[7:0]);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_output({pfx, "_pull_09"}, 32'(o_pull_09), 32'd0);
        check_output({pfx, "_pull_24"}, 32'(o_pull_24), 32'd0);
        check_output({pfx, "_valid"},   32'(o_byte_valid), 32'd0);
        check_output({pfx, "_sof"},     32'(o_sof), 32'd0);
        check_output({pfx, "_busy"},    32'(o_busy), 32'd0);
        check_output({pfx, "_byte"},    32'(o_byte), 32'd0);
        check_output({pfx, "_chan"},    32'(o_chan), 32'd0);
    endtask

    task automatic compare_outputs();
        bit ev;
        ev = m_engaged && (cyc >= m_send_from);
        check_output("valid",   32'(o_byte_valid), 32'(ev));
        check_output("busy",    32'(o_busy), 32'(m_engaged));
        check_output("pull_09", 32'(o_pull_09), 32'(m_engaged && cyc == m_pull_at && !m_chan));
        check_output("pull_24", 32'(o_pull_24), 32'(m_engaged && cyc == m_pull_at && m_chan));
        check_output("chan",    32'(o_chan), 32'(m_chan));
        check_output("sof",     32'(o_sof), 32'(ev && m_bytes.size() == 4));
        if (ev) begin
            check_output("byte", 32'(o_byte), 32'(m_bytes[0]));
        end
    endtask

    task automatic fifo_update();
        if (o_pull_09) begin
            pull_log.push_back(0);
            check_output("pull_09_nonempty", 32'(q09.size() > 0), 32'd1);
            if (q09.size() > 0) i_data_09 = q09.pop_front();
        end
        if (o_pull_24) begin
            pull_log.push_back(1);
            check_output("pull_24_nonempty", 32'(q24.size() > 0), 32'd1);
            if (q24.size() > 0) i_data_24 = q24.pop_front();
        end
        while (add09.size() > 0) q09.push_back(add09.pop_front());
        while (add24.size() > 0) q24.push_back(add24.pop_front());
        if (q09.size() < 8 && $urandom_range(0, 99) < cfg_push_pct) q09.push_back($urandom());
        if (q24.size() < 8 && $urandom_range(0, 99) < cfg_push_pct) q24.push_back($urandom());
        i_empty_09 = (q09.size() == 0);
        i_empty_24 = (q24.size() == 0);
    endtask

    task automatic apply_stimulus();
        if (cfg_rand_mode && $urandom_range(0, 9) == 0) cfg_mode = 2'($urandom_range(0, 3));
        i_mode = cfg_mode;
        case (cfg_ready)
            0:       i_byte_ready = ($urandom_range(0, 99) < 70);
            2:       i_byte_ready = ~i_byte_ready;
            default: i_byte_ready = 1'b1;
        endcase
    endtask

    // Advances the reference across the coming rising edge using the inputs just driven
    task automatic model_step();
        bit ev;
        bit done;
        bit e09;
        bit e24;
        ev   = m_engaged && (cyc >= m_send_from);
        done = 1'b0;
        if (o_byte_valid && i_byte_ready) begin
            seen_bytes.push_back(o_byte);
            acc_count++;
        end
        if (ev && i_byte_ready) begin
            void'(m_bytes.pop_front());
            done = (m_bytes.size() == 0);
        end
        e09 = i_mode[0] && (q09.size() > 0);
        e24 = i_mode[1] && (q24.size() > 0);
        if (m_engaged) begin
            if (done) begin
                if ((m_chan ? e24 : e09) && (i_mode != 2'b11 || m_burst < BURST_LEN)) begin
                    m_burst++;
                    start_word(m_chan);
                end else begin
                    m_engaged = 1'b0;
                end
            end
        end else if (e09 || e24) begin
            m_burst = 1;
            if (e09 && e24) start_word(~m_last);
            else            start_word(e24);
        end
        cyc++;
    endtask

    task automatic run_cycle();
        @(negedge i_sys_clk);
        if (i_reset) check_reset_outputs("in_reset");
        else         compare_outputs();
        fifo_update();
        apply_stimulus();
        if (release_req) begin
            i_reset     = 1'b0;
            release_req = 1'b0;
        end
        if (!i_reset) model_step();
    endtask

    // Asserts reset a little after a rising edge so its asynchronous effect is visible mid-cycle
    task automatic apply_reset(input string pfx);
        @(posedge i_sys_clk);
        #2;
        i_reset = 1'b1;
        #1;
        check_reset_outputs(pfx);
        model_reset();
        repeat (2) run_cycle();
        release_req = 1'b1;
        run_cycle();
    endtask

    initial begin
        int guard;
        int exp_order[20];
        logic [7:0] exp_bytes[4];

        model_reset();
        repeat (3) run_cycle();
        release_req = 1'b1;
        run_cycle();
        repeat (4) run_cycle();

        $display("[TB] mode 01 single word");
        cfg_mode = 2'b01;
        cfg_ready = 1;
        seen_bytes.delete();
        add09.push_back(32'hA1B2C3D4);
        repeat (12) run_cycle();
        exp_bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        check_output("w32_count", 32'(seen_bytes.size()), 32'd4);
        for (int i = 0; i < 4; i++) check_output("w32_byte", 32'(seen_bytes[i]), 32'(exp_bytes[i]));

        $display("[TB] round-robin bursts");
        apply_reset("rr_async");
        cfg_mode = 2'b11;
        pull_log.delete();
        for (int i = 0; i < 10; i++) begin
            add09.push_back($urandom());
            add24.push_back($urandom());
        end
        repeat (200) run_cycle();
        exp_order = '{0,0,0,0, 1,1,1,1, 0,0,0,0, 1,1,1,1, 0,0, 1,1};
        check_output("rr_pull_count", 32'(pull_log.size()), 32'd20);
        for (int i = 0; i < 20; i++) check_output("rr_grant", 32'(pull_log[i]), 32'(exp_order[i]));

        $display("[TB] mode 10 with toggling ready");
        cfg_mode = 2'b10;
        cfg_ready = 2;
        seen_bytes.delete();
        add24.push_back(32'h12345678);
        repeat (20) run_cycle();
        exp_bytes = '{8'h12, 8'h34, 8'h56, 8'h78};
        check_output("toggle_count", 32'(seen_bytes.size()), 32'd4);
        for (int i = 0; i < 4; i++) check_output("toggle_byte", 32'(seen_bytes[i]), 32'(exp_bytes[i]));

        $display("[TB] round-robin with 0.9GHz running dry");
        cfg_ready = 1;
        apply_reset("dry_async");
        cfg_mode = 2'b11;
        pull_log.delete();
        add09.push_back(32'h01020304);
        add09.push_back(32'h05060708);
        for (int i = 0; i < 3; i++) add24.push_back($urandom());
        repeat (80) run_cycle();
        exp_order[0:4] = '{0, 0, 1, 1, 1};
        check_output("dry_pull_count", 32'(pull_log.size()), 32'd5);
        for (int i = 0; i < 5; i++) check_output("dry_grant", 32'(pull_log[i]), 32'(exp_order[i]));

        $display("[TB] reset in the middle of a word");
        cfg_mode = 2'b01;
        acc_count = 0;
        add09.push_back(32'hDEADBEEF);
        add09.push_back(32'h11223344);
        guard = 0;
        while (acc_count < 2 && guard < 30) begin
            run_cycle();
            guard++;
        end
        check_output("midword_reach", 32'(acc_count >= 2), 32'd1);
        seen_bytes.delete();
        apply_reset("midword_async");
        repeat (20) run_cycle();
        exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        check_output("midword_count", 32'(seen_bytes.size()), 32'd4);
        for (int i = 0; i < 4; i++) check_output("midword_byte", 32'(seen_bytes[i]), 32'(exp_bytes[i]));

        $display("[TB] mode switched off during a word");
        cfg_mode = 2'b11;
        for (int i = 0; i < 3; i++) begin
            add09.push_back($urandom());
            add24.push_back($urandom());
        end
        guard = 0;
        while (!o_byte_valid && guard < 40) begin
            run_cycle();
            guard++;
        end
        check_output("off_valid_seen", 32'(o_byte_valid), 32'd1);
        seen_bytes.delete();
        pull_log.delete();
        cfg_mode = 2'b00;
        repeat (30) run_cycle();
        check_output("off_rest_bytes", 32'(seen_bytes.size()), 32'd3);
        check_output("off_no_pulls", 32'(pull_log.size()), 32'd0);
        check_output("off_idle", 32'(o_busy), 32'd0);

        $display("[TB] randomized traffic");
        apply_reset("rand_async");
        cfg_rand_mode = 1'b1;
        cfg_ready = 0;
        cfg_push_pct = 30;
        repeat (3000) run_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_fifo_sched.md
RX_FIFO_SCHED -- requirements
Module: rx_fifo_sched

Interface
REQ-001 Parameter: BURST_LEN, 4, max words drained from one channel before re-arbitration in round-robin mode (legal 1..16).
REQ-002 i_sys_clk  in  1  system clock; all logic on rising edge.
REQ-003 i_reset  in  1  reset, asynchronous, active-high.
REQ-004 i_mode  in  2  00 off, 01 0.9GHz only, 10 2.4GHz only, 11 round-robin.
REQ-005 i_empty_09 / i_empty_24  in  1 each  RX FIFO empty flags.
REQ-006 o_pull_09 / o_pull_24  out  1 each  FIFO read enables, registered.
REQ-007 i_data_09 / i_data_24  in  32 each  FIFO read data, valid the cycle after the pull.
REQ-008 o_byte  out  8  serialized sample byte.
REQ-009 o_byte_valid  out  1  o_byte valid.
REQ-010 i_byte_ready  in  1  SMI side accepts byte when high with o_byte_valid.
REQ-011 o_sof  out  1  high with the first byte of each 32-bit word.
REQ-012 o_chan  out  1  source of current word: 0 = 0.9GHz, 1 = 2.4GHz.
REQ-013 o_busy  out  1  high in any state other than IDLE.

Function
REQ-014 States: IDLE, REQ, LATCH, SEND; state is a register.
REQ-015 IDLE: eligible_09 = mode[0] & ~i_empty_09; eligible_24 = mode[1] & ~i_empty_24; none eligible -> stay IDLE.
REQ-016 Single eligible channel -> grant it; both eligible (mode 11) -> grant channel != last granted; last-granted resets to 1 (first grant goes to 0.9GHz).
REQ-017 Grant -> REQ next cycle; burst counter cleared; o_chan updated to the granted channel.
REQ-018 REQ: exactly one pull asserted on the granted channel for one cycle; -> LATCH.
REQ-019 No pull is ever asserted on a channel whose empty flag was high in the deciding cycle; the two pulls are never high together.
REQ-020 LATCH: capture the granted channel's i_data into 32-bit shift register, byte index = 0; -> SEND.
REQ-021 SEND: o_byte_valid = 1, o_byte = word[31:24], then [23:16], [15:8], [7:0]; advance only on o_byte_valid & i_byte_ready.
REQ-022 o_byte, o_chan, o_sof held stable while valid & ~ready; o_sof = 1 only while byte index = 0.
REQ-023 4th byte accepted: if mode = 11, burst count < BURST_LEN-1, same channel still eligible -> REQ (same channel, burst count +1); else -> IDLE.
REQ-024 Modes 01/10: continue same channel directly while eligible (no burst limit); else -> IDLE.
REQ-025 Latency: eligibility seen in IDLE cycle N -> pull at N+1 -> first valid byte at N+3; burst continuation: pull the cycle after the last accept.
REQ-026 Throughput with ready held high: 4 bytes per 6 cycles within a burst.
REQ-027 Mode change mid-word: current word completes with all 4 bytes; new mode applies at the next REQ/IDLE decision.
REQ-028 Mode 00 in IDLE: no pulls, o_byte_valid = 0.

Reset
REQ-029 While i_reset = 1: state IDLE; o_pull_09, o_pull_24, o_byte_valid, o_sof, o_busy = 0; o_byte = 0; o_chan = 0; last-granted = 1; byte index and burst count = 0.
REQ-030 Reset mid-word: partial word discarded, no further bytes of it emitted after release.
REQ-031 First decision is made in the first clock after i_reset deasserts.

Verification
REQ-032 Mode 01, 0.9GHz FIFO holds 0xA1B2C3D4, ready = 1 -> one pull_09, bytes A1,B2,C3,D4, sof on A1 only, chan 0, first byte 3 cycles after IDLE decision.
REQ-033 Mode 11, both FIFOs 10 words, BURST_LEN = 4, ready = 1 -> grant order 09×4, 24×4, 09×4, 24×4, 09×2, 24×2; no simultaneous pulls.
REQ-034 Mode 10, ready toggled 1/0 every cycle, word 0x12345678 -> bytes 12,34,56,78 each held stable while ready low; no pull until 4th accept.
REQ-035 Mode 11, 0.9GHz empties after 2 words while 2.4GHz non-empty -> burst ends after word 2, next grant 2.4GHz, never pull_09 while empty.
REQ-036 Assert i_reset after 2nd byte of 0xDEADBEEF -> all outputs 0 asynchronously; after release, next word begins with sof, EF never emitted.
REQ-037 Mode switched 11 -> 00 during SEND -> remaining bytes emitted, then IDLE with no further pulls.
